taxi_eth_lfc_pause_rx: RTL
==========================

// Module: taxi_eth_lfc_pause_rx
// PURPOSE
//  GMII-side receiver for IEEE 802.3 annex 31B PAUSE frames; link-partner end of the 1G MAC LFC transmit path.
//  Snoops the 8-bit GMII receive stream, detects SFD, checks CRC32, matches the PAUSE dst/type/opcode and extracts pause_time.
//  Runs a pause timer in 512-bit-time quanta and drives a pause request to the local transmitter.
// PARAMETERS
//  MIN_FRAME_LEN  64    min accepted length, dst..FCS inclusive, bytes
//  MAX_FRAME_LEN  1518  max accepted length, dst..FCS inclusive, bytes
// PORTS
//  clk                clk_enable... see below
//  clk                input   1   clock
//  rst                input   1   reset, asynchronous, active-high
//  gmii_rxd           input   8   GMII receive data
//  gmii_rx_dv         input   1   GMII receive data valid
//  gmii_rx_er         input   1   GMII receive error
//  clk_enable         input   1   byte-time strobe (1 at 1G, 1-in-10 at 100M)
//  cfg_rx_lfc_en      input   1   enable pause processing
//  cfg_rx_lfc_opcode  input   16  expected opcode (0x0001)
//  pause_req          output  1   pause active, timer nonzero
//  pause_quanta       output  16  remaining quanta
//  stat_rx_lfc_pkt    output  1   1-cycle pulse: valid PAUSE frame accepted
//  stat_rx_lfc_xon    output  1   1-cycle pulse: accepted frame had pause_time==0
//  stat_rx_lfc_xoff   output  1   1-cycle pulse: accepted frame had pause_time!=0
//  stat_rx_bad_fcs    output  1   1-cycle pulse: frame ended with CRC mismatch
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, timer 0; async assert, deassert sampled on clk. Mid-frame reset discards the frame.
//  GMII inputs are sampled only when clk_enable=1; all other cycles hold FSM, CRC, counters and timer.
//  FSM:
//   IDLE: rx_dv=1 & rxd=0x55 -> PREAMBLE; rx_dv=1 & other byte -> DROP.
//   PREAMBLE: 0x55 stays; 0xD5 -> DATA (byte_cnt=0, crc=0xFFFFFFFF, err=0); other byte -> DROP; rx_dv=0 -> IDLE.
//   DATA: each byte updates CRC32 (reflected poly 0xEDB88320) and byte_cnt (11b, saturates at 2047); rx_er=1 sets err.
//         Captures bytes 0-5 dst, 12-13 ethertype, 14-15 opcode, 16-17 pause_time (big-endian).
//         rx_dv=0 -> end-of-frame evaluation, -> IDLE.
//   DROP: wait for rx_dv=0 -> IDLE. No stats.
//  End-of-frame evaluation, cycle with clk_enable=1 & rx_dv=0 in DATA:
//   crc_ok = (crc == 0xDEBB20E3) after FCS bytes are included.
//   len_ok = MIN_FRAME_LEN <= byte_cnt <= MAX_FRAME_LEN.
//   match = dst==01-80-C2-00-00-01 & type==0x8808 & opcode==cfg_rx_lfc_opcode.
//   len_ok & !err & !crc_ok -> stat_rx_bad_fcs pulse, regardless of match or enable.
//   len_ok & !err & crc_ok & match & cfg_rx_lfc_en -> load timer; pulse stat_rx_lfc_pkt and xon or xoff.
//   All other frames are ignored silently.
//   Stat pulses and timer load are registered on that edge; they are visible on the next cycle, high for exactly one clk.
//  Timer: quanta_cnt (16b) plus sub_cnt (6b); 1 quanta = 64 byte times.
//   Load: quanta_cnt <= pause_time, sub_cnt <= 0. Load wins over a same-cycle decrement.
//   Decrement, on clk_enable=1 & quanta_cnt!=0: sub_cnt++; at sub_cnt==63, quanta_cnt-- and sub_cnt wraps to 0.
//   pause_req = (quanta_cnt != 0), registered. pause_quanta = quanta_cnt.
//   XON (pause_time 0) clears pause_req on the next cycle. A new XOFF while active reloads and restarts the timer.
//  cfg_rx_lfc_en=0 forces quanta_cnt/sub_cnt to 0 on the next edge; CRC/bad_fcs checking continues.
//  The timer runs concurrently with frame reception; a frame arriving during pause is processed normally.
// TESTING
//  Good PAUSE, pause_time=0x0002, clk_enable=1 -> one stat_rx_lfc_pkt and xoff pulse; pause_req high exactly 128 clks; pause_quanta steps 2,1,0.
//  XOFF 0xFFFF, then XON (0x0000) after 1000 clks -> stat xon pulse; pause_req low on the cycle after the XON end-of-frame.
//  PAUSE with last FCS byte bit-flipped -> stat_rx_bad_fcs pulse; pause_req and pause_quanta unchanged.
//  Valid-CRC frames: dst 02-00-00-00-00-01, or type 0x0800, or opcode 0x0101 -> no stat pulses, timer unchanged.
//  clk_enable 1-in-10, pause_time=0x0001 -> pause_req high exactly 640 clks.
//  rx_er mid-frame -> frame ignored. rst pulse while pause_req=1 -> all outputs 0 immediately.
//  Runt (60 B) PAUSE with correct CRC -> ignored.

Source files
------------

// File: rtl/taxi_eth_lfc_pause_rx.sv
// GMII receive-side PAUSE frame detector with CRC32 check and pause timer.
// Ports: clk/rst, gmii_rxd/rx_dv/rx_er, clk_enable, cfg_rx_lfc_en/opcode,
//        pause_req/pause_quanta, stat_rx_lfc_pkt/xon/xoff, stat_rx_bad_fcs.
module taxi_eth_lfc_pause_rx #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        clk_enable,
  input  logic        cfg_rx_lfc_en,
  input  logic [15:0] cfg_rx_lfc_opcode,
  output logic        pause_req,
  output logic [15:0] pause_quanta,
  output logic        stat_rx_lfc_pkt,
  output logic        stat_rx_lfc_xon,
  output logic        stat_rx_lfc_xoff,
  output logic        stat_rx_bad_fcs
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [10:0] MIN_L = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME_LEN);

  logic [1:0]  r_state;
  logic [10:0] r_cnt;
  logic [31:0] r_crc;
  logic        r_err;
  logic [47:0] r_dst;
  logic [15:0] r_type;
  logic [15:0] r_op;
  logic [15:0] r_ptime;

  logic [15:0] r_q;
  logic [5:0]  r_s;
  logic        r_req;
  logic        r_pkt;
  logic        r_xon;
  logic        r_xoff;
  logic        r_bad;

  logic [31:0] w_crc_nxt;
  logic        w_eof;
  logic        w_len_ok;
  logic        w_crc_ok;
  logic        w_match;
  logic        w_good;
  logic        w_bad;
  logic [15:0] w_q_nxt;
  logic [5:0]  w_s_nxt;

  // Reflected CRC32, one byte, LSB first; no final inversion so a
  // frame including its FCS leaves the fixed residue.
  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] v;
    v = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    end
    return v;
  endfunction

  always_comb w_crc_nxt = crc_step(r_crc, gmii_rxd);

  assign w_eof    = clk_enable & (r_state == ST_DATA) & ~gmii_rx_dv;
  assign w_len_ok = (r_cnt >= MIN_L) && (r_cnt <= MAX_L);
  assign w_crc_ok = (r_crc == 32'hDEBB20E3);
  assign w_match  = (r_dst == 48'h0180C2000001) &&
                    (r_type == 16'h8808) &&
                    (r_op == cfg_rx_lfc_opcode);
  assign w_good   = w_eof & w_len_ok & ~r_err & w_crc_ok &
                    w_match & cfg_rx_lfc_en;
  assign w_bad    = w_eof & w_len_ok & ~r_err & ~w_crc_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_crc   <= '1;
      r_err   <= 1'b0;
      r_dst   <= '0;
      r_type  <= '0;
      r_op    <= '0;
      r_ptime <= '0;
    end else if (clk_enable) begin
      unique case (r_state)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            r_state <= (gmii_rxd == 8'h55) ? ST_PRE : ST_DROP;
          end
        end
        ST_PRE: begin
          if (!gmii_rx_dv) begin
            r_state <= ST_IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_crc   <= '1;
            r_err   <= 1'b0;
          end else if (gmii_rxd != 8'h55) begin
            r_state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (!gmii_rx_dv) begin
            r_state <= ST_IDLE;
          end else begin
            r_crc <= w_crc_nxt;
            if (r_cnt != 11'h7FF) r_cnt <= r_cnt + 11'd1;
            if (gmii_rx_er) r_err <= 1'b1;
            // Header fields are big-endian; shift in by byte index.
            if (r_cnt < 11'd6) r_dst <= {r_dst[39:0], gmii_rxd};
            if (r_cnt == 11'd12) r_type[15:8] <= gmii_rxd;
            if (r_cnt == 11'd13) r_type[7:0] <= gmii_rxd;
            if (r_cnt == 11'd14) r_op[15:8] <= gmii_rxd;
            if (r_cnt == 11'd15) r_op[7:0] <= gmii_rxd;
            if (r_cnt == 11'd16) r_ptime[15:8] <= gmii_rxd;
            if (r_cnt == 11'd17) r_ptime[7:0] <= gmii_rxd;
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Disable clears, a load beats the running decrement.
  always_comb begin
    w_q_nxt = r_q;
    w_s_nxt = r_s;
    if (!cfg_rx_lfc_en) begin
      w_q_nxt = '0;
      w_s_nxt = '0;
    end else if (w_good) begin
      w_q_nxt = r_ptime;
      w_s_nxt = '0;
    end else if (clk_enable && (r_q != 16'd0)) begin
      if (r_s == 6'd63) begin
        w_q_nxt = r_q - 16'd1;
        w_s_nxt = '0;
      end else begin
        w_s_nxt = r_s + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_s    <= '0;
      r_req  <= 1'b0;
      r_pkt  <= 1'b0;
      r_xon  <= 1'b0;
      r_xoff <= 1'b0;
      r_bad  <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_s    <= w_s_nxt;
      r_req  <= (w_q_nxt != 16'd0);
      r_pkt  <= w_good;
      r_xon  <= w_good & (r_ptime == 16'd0);
      r_xoff <= w_good & (r_ptime != 16'd0);
      r_bad  <= w_bad;
    end
  end

  assign pause_req        = r_req;
  assign pause_quanta     = r_q;
  assign stat_rx_lfc_pkt  = r_pkt;
  assign stat_rx_lfc_xon  = r_xon;
  assign stat_rx_lfc_xoff = r_xoff;
  assign stat_rx_bad_fcs  = r_bad;

endmodule
